// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus bundle: instruction memory port, branch predictor
// query/response, retire redirect and the instruction-buffer side.
interface fetch_pc_ctrl_if #(
    parameter int IDX_W = 4
);
    logic [31:0]      proc2Imem_addr;
    logic [63:0]      Imem2proc_data;
    logic             Imem_valid;

    logic             if_en_branch;
    logic             if_cond_branch;
    logic             if_direct_branch;
    logic [31:0]      if_pc_in;
    logic             next_pc_valid;
    logic [31:0]      next_pc;
    logic             next_pc_prediction;
    logic [IDX_W-1:0] next_pc_index;

    logic             rt_mispredict;
    logic [31:0]      rt_calculated_pc;

    logic             ib_ready;
    logic             if_valid;
    logic [31:0]      if_inst;
    logic [31:0]      if_pc;
    logic [31:0]      if_npc;
    logic             if_pred_taken;
    logic [IDX_W-1:0] if_branch_index;

    // Fetch controller side
    modport master (
        output proc2Imem_addr,
        input  Imem2proc_data, Imem_valid,
        output if_en_branch, if_cond_branch, if_direct_branch, if_pc_in,
        input  next_pc_valid, next_pc, next_pc_prediction, next_pc_index,
        input  rt_mispredict, rt_calculated_pc,
        input  ib_ready,
        output if_valid, if_inst, if_pc, if_npc, if_pred_taken, if_branch_index
    );

    // Environment side: memory, predictor, retire and buffer
    modport slave (
        input  proc2Imem_addr,
        output Imem2proc_data, Imem_valid,
        input  if_en_branch, if_cond_branch, if_direct_branch, if_pc_in,
        output next_pc_valid, next_pc, next_pc_prediction, next_pc_index,
        output rt_mispredict, rt_calculated_pc,
        output ib_ready,
        input  if_valid, if_inst, if_pc, if_npc, if_pred_taken, if_branch_index
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: fetches one word per cycle, predecodes branches,
// queries the branch predictor combinationally and registers each fetched
// instruction with its PC, predicted next PC and OBQ index.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IDX_W    = 4
) (
    input logic             clock,
    input logic             reset,
    fetch_pc_ctrl_if.master bus
);
    typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [31:0]      pc_plus4;
    logic [31:0]      target;
    logic [31:0]      inst;
    logic [5:0]       opcode;
    logic             is_branch;
    logic             is_direct;
    logic             is_cond;
    logic             fire;
    logic             taken;

    logic             out_valid;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic [31:0]      out_npc;
    logic             out_pred_taken;
    logic [IDX_W-1:0] out_index;

    assign inst   = pc[2] ? bus.Imem2proc_data[63:32] : bus.Imem2proc_data[31:0];
    assign opcode = inst[31:26];

    assign is_direct = (opcode[5:4] == 2'b11);
    assign is_branch = is_direct || (opcode == 6'h1A);
    assign is_cond   = is_direct && (opcode != 6'h30) && (opcode != 6'h34);

    assign fire = (state == FETCH) && bus.Imem_valid && !bus.rt_mispredict &&
                  (!out_valid || bus.ib_ready);

    assign taken    = is_branch && bus.next_pc_valid && (bus.next_pc_prediction || !is_cond);
    assign pc_plus4 = pc + 32'd4;
    assign target   = taken ? bus.next_pc : pc_plus4;

    assign bus.proc2Imem_addr   = {pc[31:3], 3'b000};
    assign bus.if_pc_in         = pc;
    assign bus.if_en_branch     = fire && is_branch;
    assign bus.if_cond_branch   = fire && is_branch && is_cond;
    assign bus.if_direct_branch = fire && is_branch && is_direct;

    assign bus.if_valid        = out_valid;
    assign bus.if_inst         = out_inst;
    assign bus.if_pc           = out_pc;
    assign bus.if_npc          = out_npc;
    assign bus.if_pred_taken   = out_pred_taken;
    assign bus.if_branch_index = out_index;

    // Next PC: retire redirect beats everything, a stalled fetch holds the PC
    always_comb begin
        pc_next = pc;
        if (bus.rt_mispredict) begin
            pc_next = bus.rt_calculated_pc;
        end else if (fire) begin
            pc_next = target;
        end
    end

    // Next state: a redirect always wins so a flush cancels any pending hold
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (bus.rt_mispredict) begin
                    state_next = REDIRECT;
                end else if (out_valid && !bus.ib_ready && bus.Imem_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.rt_mispredict) begin
                    state_next = REDIRECT;
                end else if (bus.ib_ready) begin
                    state_next = FETCH;
                end
            end
            REDIRECT: begin
                if (!bus.rt_mispredict) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // PC and state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= FETCH;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    // Output register toward the instruction buffer; held while the buffer stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_inst       <= 32'h0;
            out_pc         <= 32'h0;
            out_npc        <= 32'h0;
            out_pred_taken <= 1'b0;
            out_index      <= '0;
        end else if (bus.rt_mispredict) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid      <= 1'b1;
            out_inst       <= inst;
            out_pc         <= pc;
            out_npc        <= target;
            out_pred_taken <= taken;
            out_index      <= is_branch ? bus.next_pc_index : '0;
        end else if (bus.ib_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: sequential fetch, predicted and
// unpredicted branches, buffer stall, back-to-back redirects, PC wrap,
// memory stall and reset during a hold.
module tb_fetch_pc_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    fetch_pc_ctrl_if #(.IDX_W(4)) bus ();

    fetch_pc_ctrl #(.RESET_PC(32'h0), .IDX_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_regs(input string tag, input logic valid, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [31:0] npc,
                              input logic pred, input logic [3:0] idx);
        check_output({tag, ".valid"}, 32'(bus.if_valid), 32'(valid));
        check_output({tag, ".inst"}, bus.if_inst, inst);
        check_output({tag, ".pc"}, bus.if_pc, pc);
        check_output({tag, ".npc"}, bus.if_npc, npc);
        check_output({tag, ".pred"}, 32'(bus.if_pred_taken), 32'(pred));
        check_output({tag, ".idx"}, 32'(bus.if_branch_index), 32'(idx));
    endtask

    task automatic check_bp(input string tag, input logic en, input logic cond, input logic dir);
        check_output({tag, ".en"}, 32'(bus.if_en_branch), 32'(en));
        check_output({tag, ".cond"}, 32'(bus.if_cond_branch), 32'(cond));
        check_output({tag, ".dir"}, 32'(bus.if_direct_branch), 32'(dir));
    endtask

    task automatic set_bp(input logic valid, input logic pred, input logic [31:0] npc,
                          input logic [3:0] idx);
        bus.next_pc_valid      = valid;
        bus.next_pc_prediction = pred;
        bus.next_pc            = npc;
        bus.next_pc_index      = idx;
    endtask

    initial begin
        reset                = 1'b1;
        bus.Imem_valid       = 1'b0;
        bus.Imem2proc_data   = 64'h0;
        bus.rt_mispredict    = 1'b0;
        bus.rt_calculated_pc = 32'h0;
        bus.ib_ready         = 1'b1;
        set_bp(1'b0, 1'b0, 32'h0, 4'd0);
        tick();
        tick();
        check_regs("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

        // Reset released: PC visible on the memory and predictor ports
        reset = 1'b0;
        #1;
        check_output("rst.addr", bus.proc2Imem_addr, 32'h0);
        check_output("rst.pcin", bus.if_pc_in, 32'h0);

        // Sequential non-branch fetch at 0 and 4 (lower then upper half)
        bus.Imem_valid     = 1'b1;
        bus.Imem2proc_data = {32'h4400_0002, 32'h4000_0001};
        #1;
        check_bp("seq0", 1'b0, 1'b0, 1'b0);
        tick();
        check_regs("seq0", 1'b1, 32'h4000_0001, 32'h0, 32'h4, 1'b0, 4'd0);
        #1;
        check_output("seq1.pcin", bus.if_pc_in, 32'h4);
        check_output("seq1.addr", bus.proc2Imem_addr, 32'h0);
        check_bp("seq1", 1'b0, 1'b0, 1'b0);
        tick();
        check_regs("seq1", 1'b1, 32'h4400_0002, 32'h4, 32'h8, 1'b0, 4'd0);

        // Indirect JMP at 8: unconditional, taken on a valid target even with pred=0
        bus.Imem2proc_data = {32'h0, 32'h6800_0000};
        set_bp(1'b1, 1'b0, 32'h50, 4'd1);
        #1;
        check_bp("jmp", 1'b1, 1'b0, 1'b0);
        tick();
        check_regs("jmp", 1'b1, 32'h6800_0000, 32'h8, 32'h50, 1'b1, 4'd1);

        // Conditional direct branch 0x39 at 0x50 predicted taken to 0xA0
        bus.Imem2proc_data = {32'h0, 32'hE400_0000};
        set_bp(1'b1, 1'b1, 32'hA0, 4'd3);
        #1;
        check_output("br.pcin", bus.if_pc_in, 32'h50);
        check_bp("br", 1'b1, 1'b1, 1'b1);
        tick();
        check_regs("br", 1'b1, 32'hE400_0000, 32'h50, 32'hA0, 1'b1, 4'd3);

        // Non-branch at 0xA0: no BP pulse, index forced to 0
        bus.Imem2proc_data = {32'hC000_0000, 32'h4000_0010};
        set_bp(1'b0, 1'b1, 32'h123, 4'd5);
        #1;
        check_output("tgt.pcin", bus.if_pc_in, 32'hA0);
        check_bp("tgt", 1'b0, 1'b0, 1'b0);
        tick();
        check_regs("tgt", 1'b1, 32'h4000_0010, 32'hA0, 32'hA4, 1'b0, 4'd0);

        // BR 0x30 at 0xA4 with no BTB hit: falls through to PC+4
        set_bp(1'b0, 1'b1, 32'h123, 4'd6);
        #1;
        check_output("nohit.addr", bus.proc2Imem_addr, 32'hA0);
        check_bp("nohit", 1'b1, 1'b0, 1'b1);
        tick();
        check_regs("nohit", 1'b1, 32'hC000_0000, 32'hA4, 32'hA8, 1'b0, 4'd6);

        // BSR 0x34 at 0xA8 taken to 0x400
        bus.Imem2proc_data = {32'h0, 32'hD000_0000};
        set_bp(1'b1, 1'b0, 32'h400, 4'd7);
        #1;
        check_bp("bsr", 1'b1, 1'b0, 1'b1);
        tick();
        check_regs("bsr", 1'b1, 32'hD000_0000, 32'hA8, 32'h400, 1'b1, 4'd7);

        // Buffer stall for 3 cycles with a branch waiting at 0x400
        bus.ib_ready       = 1'b0;
        bus.Imem2proc_data = {32'h0, 32'hE400_0000};
        set_bp(1'b1, 1'b0, 32'h999, 4'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("stall.en", 32'(bus.if_en_branch), 32'h0);
            check_output("stall.pcin", bus.if_pc_in, 32'h400);
            tick();
            check_regs("stall", 1'b1, 32'hD000_0000, 32'hA8, 32'h400, 1'b1, 4'd7);
        end
        bus.ib_ready = 1'b1;
        #1;
        check_output("release.en", 32'(bus.if_en_branch), 32'h0);
        tick();
        check_output("release.valid", 32'(bus.if_valid), 32'h0);
        #1;
        check_bp("resume", 1'b1, 1'b1, 1'b1);
        tick();
        check_regs("resume", 1'b1, 32'hE400_0000, 32'h400, 32'h404, 1'b0, 4'd2);

        // Enter HOLD at 0x404, then mispredict to 0x200 and again to 0x300
        bus.ib_ready       = 1'b0;
        bus.Imem2proc_data = {32'h4000_0020, 32'hE400_0000};
        #1;
        check_output("hold.en", 32'(bus.if_en_branch), 32'h0);
        tick();
        check_output("hold.valid", 32'(bus.if_valid), 32'h1);
        bus.rt_mispredict    = 1'b1;
        bus.rt_calculated_pc = 32'h200;
        #1;
        check_output("mp1.en", 32'(bus.if_en_branch), 32'h0);
        tick();
        check_output("mp1.valid", 32'(bus.if_valid), 32'h0);
        check_output("mp1.addr", bus.proc2Imem_addr, 32'h200);
        bus.rt_calculated_pc = 32'h300;
        #1;
        check_output("mp2.en", 32'(bus.if_en_branch), 32'h0);
        tick();
        check_output("mp2.valid", 32'(bus.if_valid), 32'h0);
        check_output("mp2.pcin", bus.if_pc_in, 32'h300);
        bus.rt_mispredict  = 1'b0;
        bus.ib_ready       = 1'b1;
        bus.Imem2proc_data = {32'h0, 32'hE400_0000};
        set_bp(1'b0, 1'b0, 32'h0, 4'd2);
        #1;
        check_output("bubble.en", 32'(bus.if_en_branch), 32'h0);
        tick();
        check_output("bubble.valid", 32'(bus.if_valid), 32'h0);
        #1;
        check_bp("refetch", 1'b1, 1'b1, 1'b1);
        tick();
        check_regs("refetch", 1'b1, 32'hE400_0000, 32'h300, 32'h304, 1'b0, 4'd2);

        // Redirect to 0xFFFFFFFC, stall memory for 2 cycles, then wrap to 0
        bus.rt_mispredict    = 1'b1;
        bus.rt_calculated_pc = 32'hFFFF_FFFC;
        #1;
        check_output("wrapmp.en", 32'(bus.if_en_branch), 32'h0);
        tick();
        check_output("wrapmp.valid", 32'(bus.if_valid), 32'h0);
        bus.rt_mispredict = 1'b0;
        tick();
        bus.Imem_valid     = 1'b0;
        bus.Imem2proc_data = {32'hE400_0000, 32'h0};
        set_bp(1'b1, 1'b1, 32'h40, 4'd4);
        for (int i = 0; i < 2; i++) begin
            #1;
            check_output("memstall.en", 32'(bus.if_en_branch), 32'h0);
            check_output("memstall.pcin", bus.if_pc_in, 32'hFFFF_FFFC);
            check_output("memstall.addr", bus.proc2Imem_addr, 32'hFFFF_FFF8);
            tick();
            check_output("memstall.valid", 32'(bus.if_valid), 32'h0);
        end
        bus.Imem_valid     = 1'b1;
        bus.Imem2proc_data = {32'h4000_0030, 32'h0};
        set_bp(1'b0, 1'b0, 32'h0, 4'd4);
        #1;
        check_output("wrap.en", 32'(bus.if_en_branch), 32'h0);
        tick();
        check_regs("wrap", 1'b1, 32'h4000_0030, 32'hFFFF_FFFC, 32'h0, 1'b0, 4'd0);
        #1;
        check_output("wrap.pcin", bus.if_pc_in, 32'h0);
        check_output("wrap.addr", bus.proc2Imem_addr, 32'h0);

        // Reset during HOLD returns to FETCH with cleared outputs
        bus.Imem2proc_data = {32'h0, 32'h4000_0040};
        bus.ib_ready       = 1'b0;
        tick();
        check_output("prerst.pc", bus.if_pc, 32'hFFFF_FFFC);
        reset = 1'b1;
        tick();
        check_regs("midrst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
        reset        = 1'b0;
        bus.ib_ready = 1'b1;
        #1;
        check_output("postrst.pcin", bus.if_pc_in, 32'h0);
        tick();
        check_regs("postrst", 1'b1, 32'h4000_0040, 32'h0, 32'h4, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
